// File: rtl/rom_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_load_ctrl_if
// Purpose  : Bundles the HPS ioctl download bus and the ROM write port that
//            rom_load_ctrl sits between.
//            master : the environment side (HPS download engine driving the
//                     ioctl_* strobes, ROM memory reporting mem_busy).
//            slave  : the controller side (consumes ioctl_*, drives
//                     back-pressure and the ROM write strobes).
// Signals  : ioctl_download  download in progress
//            ioctl_wr        one-cycle byte-valid strobe
//            ioctl_addr[17]  byte address within the download
//            ioctl_dout[8]   download byte
//            ioctl_index[8]  download type
//            ioctl_wait      back-pressure to the HPS
//            mem_busy        ROM write port cannot accept a write this cycle
//            rom_addr[16]    region-relative write address
//            rom_data[8]     write data
//            rom_we[4]       one-hot write strobe per region
// Revision : 1.0 - initial release
// ============================================================================
interface rom_load_ctrl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic        mem_busy;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output mem_busy,
    input  ioctl_wait, rom_addr, rom_data, rom_we
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  mem_busy,
    output ioctl_wait, rom_addr, rom_data, rom_we
  );
endinterface
`default_nettype wire

// File: rtl/rom_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_load_ctrl
// Purpose  : Streams an HPS ROM download into four ROM regions of the
//            williams2 core, throttling the HPS with ioctl_wait, and holds the
//            core in reset during the download plus HOLD_CYCLES afterwards.
//            Reports whether a complete image was received.
// Params   : HOLD_CYCLES  cycles core_reset stays high after a download ends
//            ROM_INDEX    the only ioctl_index accepted as a ROM download
//            IMAGE_BYTES  byte count of a complete image (count saturates here)
// Ports    : clk_sys      single clock, rising edge
//            reset        synchronous, active-high
//            bus          rom_load_ctrl_if.slave (ioctl bus + ROM write port)
//            core_reset   holds the core in reset
//            load_done    last download delivered a full image
//            load_short   last download ended short of a full image
// Revision : 1.0 - initial release
// ============================================================================
module rom_load_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter int unsigned IMAGE_BYTES = 131072
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  rom_load_ctrl_if.slave        bus,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_short
);

  localparam int unsigned HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [17:0]       FULL_COUNT = 18'(IMAGE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [15:0]         addr_q,      addr_d;
  logic [7:0]          data_q,      data_d;
  logic [1:0]          region_q,    region_d;
  logic [3:0]          we_q,        we_d;
  logic                wait_q,      wait_d;
  logic [17:0]         count_q,     count_d;
  logic                done_q,      done_d;
  logic                short_q,     short_d;
  logic                active_q,    active_d;
  logic                hold_pend_q, hold_pend_d;
  logic                boot_hold_q, boot_hold_d;
  logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;

  // Download qualification and edges (only the ROM index counts).
  logic        dl_active;
  logic        dl_start;
  logic        dl_fall;
  logic        accept;
  logic        pend_now;
  logic [17:0] count_base;
  logic [17:0] count_inc;

  // Region decode of the incoming address.
  logic [1:0]  region_dec;
  logic [15:0] addr_dec;

  assign dl_active = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign dl_start  = dl_active && !active_q;
  assign dl_fall   = active_q && !bus.ioctl_download;
  assign accept    = dl_active && bus.ioctl_wr;
  // A restart cancels a hold that was deferred behind an in-flight write.
  assign pend_now  = hold_pend_q && !dl_start;

  // A new download zeroes the count in the same cycle any increment lands.
  assign count_base = dl_start ? 18'd0 : count_q;
  assign count_inc  = (count_base == FULL_COUNT) ? FULL_COUNT : count_base + 18'd1;

  always_comb begin
    region_dec = 2'd0;
    addr_dec   = bus.ioctl_addr[15:0];
    if (bus.ioctl_addr[16]) begin
      // 0x10000-0x17FFF graphics, 0x18000-0x1FFFF video PROM/decoder.
      region_dec = bus.ioctl_addr[15] ? 2'd3 : 2'd2;
      addr_dec   = {1'b0, bus.ioctl_addr[14:0]};
    end else if (bus.ioctl_addr[15:14] == 2'b11) begin
      // 0x0C000-0x0FFFF sound CPU.
      region_dec = 2'd1;
      addr_dec   = {2'b00, bus.ioctl_addr[13:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    region_d    = region_q;
    we_d        = 4'b0000;
    count_d     = count_base;
    done_d      = done_q;
    short_d     = short_q;
    active_d    = dl_active;
    hold_pend_d = hold_pend_q;
    boot_hold_d = boot_hold_q;
    hold_cnt_d  = hold_cnt_q;

    if (dl_start) begin
      done_d      = 1'b0;
      short_d     = 1'b0;
      hold_pend_d = 1'b0;
      boot_hold_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = addr_dec;
          data_d   = bus.ioctl_dout;
          region_d = region_dec;
          state_d  = ST_LATCH;
        end else if (boot_hold_q && !dl_active) begin
          // Post-reset hold: no download verdict is recorded.
          boot_hold_d = 1'b0;
          hold_cnt_d  = HOLD_LOAD;
          state_d     = ST_HOLD;
        end else if (dl_fall || pend_now) begin
          hold_pend_d = 1'b0;
          hold_cnt_d  = HOLD_LOAD;
          done_d      = (count_base == FULL_COUNT);
          short_d     = (count_base != FULL_COUNT);
          state_d     = ST_HOLD;
        end
      end

      ST_LATCH: begin
        // Download end is remembered and acted on once the byte is written.
        if (dl_fall) begin
          hold_pend_d = 1'b1;
        end
        if (!bus.mem_busy) begin
          we_d    = 4'b0001 << region_q;
          count_d = count_inc;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (dl_fall) begin
          hold_pend_d = 1'b1;
        end
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (dl_fall || pend_now) begin
          hold_pend_d = 1'b0;
          hold_cnt_d  = HOLD_LOAD;
          done_d      = (count_base == FULL_COUNT);
          short_d     = (count_base != FULL_COUNT);
          state_d     = ST_HOLD;
        end else if (accept) begin
          // ioctl_wait is already low here, so the HPS may legally offer the
          // next byte; taking it now avoids silently dropping it.
          addr_d   = addr_dec;
          data_d   = bus.ioctl_dout;
          region_d = region_dec;
          state_d  = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (dl_start) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Back-pressure covers the whole capture-to-write window.
    wait_d = (state_d == ST_LATCH) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 16'd0;
      data_q      <= 8'd0;
      region_q    <= 2'd0;
      we_q        <= 4'b0000;
      wait_q      <= 1'b0;
      count_q     <= 18'd0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      active_q    <= 1'b0;
      hold_pend_q <= 1'b0;
      boot_hold_q <= 1'b1;
      hold_cnt_q  <= HOLD_LOAD;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      region_q    <= region_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      done_q      <= done_d;
      short_q     <= short_d;
      active_q    <= active_d;
      hold_pend_q <= hold_pend_d;
      boot_hold_q <= boot_hold_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // boot_hold_q keeps the core in reset from reset until the hold starts.
  assign core_reset     = boot_hold_q || dl_active || (state_q != ST_IDLE);
  assign load_done      = done_q;
  assign load_short     = short_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.rom_addr   = addr_q;
  assign bus.rom_data   = data_q;
  assign bus.rom_we     = we_q;

endmodule
`default_nettype wire
